// File: rtl/mem_bus_master_pkg.sv
// mem_bus_master_pkg: FSM states, lane mask encodings and field widths shared by the bus master.
package mem_bus_master_pkg;
  localparam int DATA_W = 16;
  localparam int BYTE_W = 8;
  localparam int MASK_W = 2;
  localparam logic [MASK_W-1:0] MASK_NONE = 2'b11;
  localparam logic [MASK_W-1:0] MASK_LOW  = 2'b10;
  localparam logic [MASK_W-1:0] MASK_HIGH = 2'b01;
  localparam logic [MASK_W-1:0] MASK_WORD = 2'b00;
  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ_WAIT, S_CAPTURE, S_RESP} state_t;
endpackage

// File: rtl/mem_bus_master_if.sv
// mem_bus_master_if: core request/response channel plus synchronous memory port.
interface mem_bus_master_if #(parameter int ADDR_WIDTH = 12);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_address;
  logic                  req_write;
  logic                  req_byte;
  logic [15:0]           req_data;
  logic                  resp_valid;
  logic [15:0]           resp_data;
  logic                  resp_error;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [15:0]           mem_data_out;
  logic [15:0]           mem_data_in;
  logic [1:0]            mem_write_mask;
  logic                  mem_write_enable;
  modport master (
    input  req_valid, req_address, req_write, req_byte, req_data, mem_data_in,
    output req_ready, resp_valid, resp_data, resp_error,
           mem_address, mem_data_out, mem_write_mask, mem_write_enable
  );
  modport slave (
    output req_valid, req_address, req_write, req_byte, req_data, mem_data_in,
    input  req_ready, resp_valid, resp_data, resp_error,
           mem_address, mem_data_out, mem_write_mask, mem_write_enable
  );
endinterface

// File: rtl/mem_bus_master_lane_steer.sv
// mem_bus_master_lane_steer: byte-lane write replication/masking and read-lane selection.
module mem_bus_master_lane_steer
  import mem_bus_master_pkg::*;
(
  input  logic              wr_byte,
  input  logic              wr_lane,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] wr_word,
  output logic [MASK_W-1:0] wr_mask,
  input  logic              rd_byte,
  input  logic              rd_lane,
  input  logic [DATA_W-1:0] rd_word,
  output logic [DATA_W-1:0] rd_data
);
  always_comb begin
    wr_word = wr_byte ? {wr_data[BYTE_W-1:0], wr_data[BYTE_W-1:0]} : wr_data;
    wr_mask = wr_byte ? (wr_lane ? MASK_HIGH : MASK_LOW) : MASK_WORD;
    rd_data = rd_byte ? {{BYTE_W{1'b0}}, rd_lane ? rd_word[DATA_W-1:BYTE_W] : rd_word[BYTE_W-1:0]}
                      : rd_word;
  end
endmodule

// File: rtl/mem_bus_master.sv
// mem_bus_master: sequences one byte/word core request onto a registered-read memory port.
// Define ODD_ADDRESS_TRAP_EN to answer odd-address word accesses with resp_error and no memory cycle.
module mem_bus_master
  import mem_bus_master_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int READ_WAIT  = 1
) (
  input logic clk,
  input logic reset_n,
  mem_bus_master_if.master bus
);
  state_t            state;
  logic              byte_q;
  logic [1:0]        wait_cnt;
  logic              odd;
  logic [DATA_W-1:0] wr_word;
  logic [DATA_W-1:0] rd_data;
  logic [MASK_W-1:0] wr_mask;

`ifdef ODD_ADDRESS_TRAP_EN
  assign odd = !bus.req_byte && bus.req_address[0];
`else
  assign odd = 1'b0;
`endif

  // read lane comes from the latched address, write lane from the live request
  mem_bus_master_lane_steer steer (
    .wr_byte(bus.req_byte),
    .wr_lane(bus.req_address[0]),
    .wr_data(bus.req_data),
    .wr_word(wr_word),
    .wr_mask(wr_mask),
    .rd_byte(byte_q),
    .rd_lane(bus.mem_address[0]),
    .rd_word(bus.mem_data_in),
    .rd_data(rd_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                <= S_IDLE;
      byte_q               <= 1'b0;
      wait_cnt             <= 2'd0;
      bus.req_ready        <= 1'b1;
      bus.resp_valid       <= 1'b0;
      bus.resp_error       <= 1'b0;
      bus.resp_data        <= '0;
      bus.mem_address      <= {ADDR_WIDTH{1'b0}};
      bus.mem_data_out     <= '0;
      bus.mem_write_mask   <= MASK_NONE;
      bus.mem_write_enable <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (bus.req_valid) begin
          bus.req_ready <= 1'b0;
          byte_q        <= bus.req_byte;
          if (odd) begin
            state          <= S_RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_error <= 1'b1;
            bus.resp_data  <= '0;
          end else begin
            bus.mem_address  <= bus.req_address;
            bus.mem_data_out <= wr_word;
            if (bus.req_write) begin
              state                <= S_WRITE;
              bus.mem_write_enable <= 1'b1;
              bus.mem_write_mask   <= wr_mask;
            end else begin
              state    <= S_READ_WAIT;
              wait_cnt <= 2'(READ_WAIT - 1);
            end
          end
        end
        S_WRITE: begin
          state                <= S_RESP;
          bus.mem_write_enable <= 1'b0;
          bus.mem_write_mask   <= MASK_NONE;
          bus.resp_valid       <= 1'b1;
          bus.resp_error       <= 1'b0;
          bus.resp_data        <= '0;
        end
        S_READ_WAIT: begin
          if (wait_cnt == 2'd0) state <= S_CAPTURE;
          else wait_cnt <= wait_cnt - 2'd1;
        end
        S_CAPTURE: begin
          state          <= S_RESP;
          bus.resp_valid <= 1'b1;
          bus.resp_error <= 1'b0;
          bus.resp_data  <= rd_data;
        end
        S_RESP: begin
          state          <= S_IDLE;
          bus.req_ready  <= 1'b1;
          bus.resp_valid <= 1'b0;
          bus.resp_error <= 1'b0;
          bus.resp_data  <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/mem_bus_master.md
# mem_bus_master

Bus initiator between the PDP-11 core's load/store logic and the synchronous word-wide program/data memory. It accepts one byte or word request at a time from the core and sequences it onto the memory port. That port has a byte address, active-low byte-lane write masks, a write enable, and a registered read with one cycle of latency. It returns read data or a write acknowledge through a single-cycle response pulse, and it flags odd-address word accesses as errors.

## Interface
Parameters:
- ADDR_WIDTH, 12: byte address width on both sides; bit 0 selects the byte lane.
- READ_WAIT, 1: cycles from the cycle the memory sees a read address until its data_out is valid; legal range 1..3.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  core presents a request.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_address  in  ADDR_WIDTH  byte address.
- req_write  in  1  1 = write, 0 = read.
- req_byte  in  1  1 = byte access, 0 = word access.
- req_data  in  16  write data; byte writes use [7:0].
- resp_valid  out  1  one-cycle pulse that completes a request.
- resp_data  out  16  read result; byte reads are zero-extended; 0 for writes and errors.
- resp_error  out  1  qualifies resp_valid; set for odd-address word access.
- mem_address  out  ADDR_WIDTH  byte address to memory.
- mem_data_out  out  16  write data to memory.
- mem_data_in  in  16  read data from memory.
- mem_write_mask  out  2  active-low lane enables: [0] low byte, [1] high byte.
- mem_write_enable  out  1  memory write strobe.

## Operation
- States: IDLE, WRITE, READ_WAIT, CAPTURE, RESP.
- IDLE: req_ready = 1. When req_valid && req_ready, the block registers address, write, byte and data.
  - Error case (next state RESP with error): word access with address[0]=1, when the error check is compiled in.
  - Write: next state WRITE.
  - Read: next state READ_WAIT.
- WRITE: exactly one cycle with mem_write_enable = 1, then RESP.
  - Word write: mask 2'b00; data passed straight through.
  - Byte write: req_data[7:0] is replicated onto both lanes. The mask enables only the lane selected by address[0]: 2'b10 for even, 2'b01 for odd.
- READ_WAIT: mem_write_enable = 0 and mem_address held. A counter runs READ_WAIT cycles, then the block moves to CAPTURE.
- CAPTURE: the block samples mem_data_in and then moves to RESP.
  - Word read: the full word.
  - Byte read: lane address[0] selected, upper byte forced to 0.
- RESP: resp_valid = 1 for one cycle with resp_data and resp_error, then IDLE. req_ready = 0 in this state.
- mem_write_mask is 2'b11 in every state except WRITE.
- mem_address and mem_data_out are registered and stable from the cycle after acceptance until the request leaves RESP.
- Requests present while req_ready = 0 are ignored; the core holds them.

## Timing
- Reset values: state IDLE, req_ready 1, resp_valid 0, resp_error 0, resp_data 0, mem_address 0, mem_data_out 0, mem_write_mask 2'b11, mem_write_enable 0.
- Reset mid-request: the request is abandoned with no response. mem_write_enable drops asynchronously, so an in-flight write does not complete after reset asserts.
- The accept cycle is N.
  - Write: mem_write_enable in N+1, resp_valid in N+2.
  - Read: address at memory in N+1, resp_valid in N+2+READ_WAIT (N+3 by default).
  - Error: resp_valid in N+1; memory is never accessed.
- Back-to-back requests: the next accept can occur in the cycle after RESP. That gives a write throughput of 1 per 3 cycles, and for reads 1 per 3+READ_WAIT cycles (4 with the default READ_WAIT=1).

## Configuration
- ODD_ADDRESS_TRAP_EN defined: an odd-address word access gets resp_error = 1 in N+1, resp_data = 0, and no memory cycle.
- ODD_ADDRESS_TRAP_EN undefined: resp_error is tied to 0. A word access ignores address[0] and uses the aligned word, matching the memory's own aligned addressing.

## Structure
- Shared package: the state enum, the mask constants MASK_NONE = 2'b11, MASK_LOW = 2'b10, MASK_HIGH = 2'b01 and MASK_WORD = 2'b00, and the request field width constants.
- Sub-module lane_steer: a combinational helper that produces write-data replication and the mask from byte/address[0], and does read-lane selection. The FSM stays in mem_bus_master.

## Test plan
Bench uses a behavioural model of the memory port with READ_WAIT=1.
- Reset: hold reset_n low for 3 cycles with req_valid high -> outputs stay at reset values, req_ready 1, no memory write.
- Word write, addr 0x010, data 0xBEEF -> in N+1 enable 1, mask 00, address 0x010; in N+2 resp_valid 1. A word read of 0x010 then returns 0xBEEF in N+3.
- Byte write 0x5A to addr 0x011 after the word above -> mask 01 in N+1. A word read of 0x010 then returns 0x5AEF; a byte read of 0x011 returns 0x005A; a byte read of 0x010 returns 0x00EF.
- Odd word read at 0x013:
  - With ODD_ADDRESS_TRAP_EN: resp_valid and resp_error in N+1, mem_write_enable never asserts, mem_address unchanged.
  - Without it: the word at 0x012 is returned with resp_error 0.
- Write at 0x020 immediately followed by a read at 0x020, req_valid held high -> the second accept occurs in the cycle after the first RESP, and the read returns the written data.
- Assert reset_n low in WRITE -> mem_write_enable falls in the same cycle, the memory word is unchanged, and no resp_valid appears.
